bus_scheduler: RTL
==================

BUS_SCHEDULER -- requirements
Module: bus_scheduler

Interface
REQ-001 SHALL provide parameter MAX_BEATS, default 8, meaning the maximum beats per tenure before forced release (legal range 1..15).
REQ-002 SHALL provide parameter TIMEOUT, default 4, meaning the consecutive idle cycles in a tenure before forced release (legal range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports Req1, Req2, Req3  input  1 each  bus request from masters 1..3, level-held.
REQ-006 SHALL have port Valid  input  1  beat-transfer strobe from the current owner.
REQ-007 SHALL have ports Ack1, Ack2, Ack3  output  1 each  bus grant to masters 1..3.
REQ-008 SHALL have port Owner  output  2  current owner: 0 = none, 1..3 = master number.
REQ-009 SHALL have port BeatCount  output  4  beats completed in the current tenure.
REQ-010 SHALL have ports Preempt and Timeout  output  1 each  one-cycle release-cause pulses.

Function
REQ-011 SHALL implement three states: IDLE, GRANT and RELEASE.
REQ-012 SHALL drive every output only from registers, with no combinational path from any input to any output.
REQ-013 SHALL, in IDLE with any Req high, select the winner round-robin starting at (LastOwner mod 3)+1, latch it as Owner, clear BeatCount and the idle counter, and enter GRANT on the next edge.
REQ-014 SHALL remain in IDLE, with Owner = 0, while no Req is high.
REQ-015 SHALL assert AckN only while the state is GRANT and Owner = N, so that AckN rises on the edge after ReqN is sampled in IDLE (1-cycle latency).
REQ-016 SHALL, in GRANT, increment BeatCount and clear the idle counter on each cycle with Valid = 1, and increment the idle counter on each cycle with Valid = 0.
REQ-017 SHALL ignore Valid in every state other than GRANT.
REQ-018 SHALL leave GRANT for RELEASE when the owner's Req is low, when a Valid beat makes BeatCount reach MAX_BEATS, or when the idle counter reaches TIMEOUT.
REQ-019 SHALL pulse Preempt for one cycle, coincident with entry to RELEASE, when the exit is due to the beat limit while the owner's Req is still high.
REQ-020 SHALL pulse Timeout for one cycle, coincident with entry to RELEASE, when the exit is due to the idle limit while the owner's Req is still high.
REQ-021 SHALL give priority to the owner's Req being low whenever several exit causes occur in the same cycle; in that case neither Preempt nor Timeout pulses.
REQ-022 SHALL hold all Acks low in RELEASE for exactly one cycle (bus turnaround), record LastOwner = Owner, and then enter IDLE unconditionally.
REQ-023 SHALL hold BeatCount through RELEASE, clear it on entry to GRANT, and never let it exceed MAX_BEATS.
REQ-024 SHALL never assert more than one Ack in the same cycle.
REQ-025 SHALL set Owner = 0 in IDLE and RELEASE.
REQ-026 SHALL route any unreachable state encoding to IDLE on the next edge with all Acks low.

Reset
REQ-027 SHALL, on assertion of reset, immediately set state = IDLE, Ack1..3 = 0, Owner = 0, BeatCount = 0, Preempt = 0, Timeout = 0, idle counter = 0 and LastOwner = 3 (so master 1 has first priority).
REQ-028 SHALL, when reset is asserted mid-tenure, drop the Ack asynchronously and discard the tenure, with no Preempt or Timeout pulse.
REQ-029 SHALL, on release of reset, begin arbitration at the first rising clk edge.

Verification
REQ-030 Verification SHALL cover: Req1..3 = 111 from reset -> Ack1 one cycle later, then after Req1 drops: RELEASE, then Ack2; after Req2 drops: RELEASE, then Ack3 (rotation 1 -> 2 -> 3).
REQ-031 Verification SHALL cover: MAX_BEATS = 8, Req2 held high, Valid = 1 continuously -> BeatCount steps 1..8, Preempt pulses once, Ack2 low for 1 RELEASE cycle plus 1 IDLE cycle, then Ack2 high again with BeatCount = 0.
REQ-032 Verification SHALL cover: TIMEOUT = 4, owner 1 with Valid = 0 -> Timeout pulse on the 4th idle cycle, Ack1 low, BeatCount unchanged.
REQ-033 Verification SHALL cover: in the final beat cycle (BeatCount 7 -> 8), Req3 drops together with Valid = 1 -> RELEASE entered, Preempt = 0, Timeout = 0.
REQ-034 Verification SHALL cover: reset asserted mid-tenure at BeatCount = 5 -> all outputs 0 without a clk edge; after release, Req2 = Req3 = 1 -> Ack2 granted first (LastOwner = 3).
REQ-035 Verification SHALL cover: toggling Valid while in IDLE -> BeatCount stays 0 and no Ack is asserted.

Source files
------------

// File: rtl/bus_scheduler_if.sv
// rtl/bus_scheduler_if.sv - request/grant bundle between bus masters and the scheduler
interface bus_scheduler_if;
  logic       Req1;
  logic       Req2;
  logic       Req3;
  logic       Valid;
  logic       Ack1;
  logic       Ack2;
  logic       Ack3;
  logic [1:0] Owner;
  logic [3:0] BeatCount;
  logic       Preempt;
  logic       Timeout;

  modport slave (
    input  Req1, Req2, Req3, Valid,
    output Ack1, Ack2, Ack3, Owner, BeatCount, Preempt, Timeout
  );

  modport master (
    output Req1, Req2, Req3, Valid,
    input  Ack1, Ack2, Ack3, Owner, BeatCount, Preempt, Timeout
  );
endinterface

// File: rtl/bus_scheduler.sv
// rtl/bus_scheduler.sv - three-master round-robin bus scheduler with beat limit and idle timeout
module bus_scheduler #(
  parameter int MAX_BEATS = 8,
  parameter int TIMEOUT   = 4
) (
  input logic            clk,
  input logic            reset,
  bus_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BEATS);
  localparam logic [3:0] TO_C  = 4'(TIMEOUT);

  state_t     state_q, state_d;
  logic [1:0] cur_q, cur_d;        // tenure owner, kept through RELEASE
  logic [1:0] last_q, last_d;      // previous owner, seeds the rotation
  logic [1:0] owner_q, owner_d;    // visible owner, zero outside GRANT
  logic [3:0] beat_q, beat_d;
  logic [3:0] idle_q, idle_d;
  logic [2:0] ack_q, ack_d;
  logic       preempt_q, preempt_d;
  logic       timeout_q, timeout_d;
  logic [1:0] winner;
  logic       own_req;

  // Round-robin pick: search starts at the master after the last owner
  always_comb begin
    winner = 2'd0;
    case (last_q)
      2'd1: begin
        if (bus.Req2) winner = 2'd2;
        else if (bus.Req3) winner = 2'd3;
        else if (bus.Req1) winner = 2'd1;
      end
      2'd2: begin
        if (bus.Req3) winner = 2'd3;
        else if (bus.Req1) winner = 2'd1;
        else if (bus.Req2) winner = 2'd2;
      end
      default: begin
        if (bus.Req1) winner = 2'd1;
        else if (bus.Req2) winner = 2'd2;
        else if (bus.Req3) winner = 2'd3;
      end
    endcase
  end

  // Request line of whoever currently holds the tenure
  always_comb begin
    own_req = 1'b0;
    case (cur_q)
      2'd1:    own_req = bus.Req1;
      2'd2:    own_req = bus.Req2;
      2'd3:    own_req = bus.Req3;
      default: own_req = 1'b0;
    endcase
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    last_d    = last_q;
    beat_d    = beat_q;
    idle_d    = idle_q;
    preempt_d = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Req1 || bus.Req2 || bus.Req3) begin
          cur_d   = winner;
          beat_d  = 4'd0;
          idle_d  = 4'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus.Valid) begin
          beat_d = beat_q + 4'd1;
          idle_d = 4'd0;
        end else begin
          idle_d = idle_q + 4'd1;
        end
        // A dropped request outranks both limits and suppresses the cause pulses
        if (!own_req) begin
          state_d = RELEASE;
        end else if (bus.Valid && (beat_q + 4'd1 == MAX_B)) begin
          state_d   = RELEASE;
          preempt_d = 1'b1;
        end else if (!bus.Valid && (idle_q + 4'd1 == TO_C)) begin
          state_d   = RELEASE;
          timeout_d = 1'b1;
        end
      end
      RELEASE: begin
        last_d  = cur_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    owner_d = (state_d == GRANT) ? cur_d : 2'd0;
    ack_d   = {3{state_d == GRANT}} & {cur_d == 2'd3, cur_d == 2'd2, cur_d == 2'd1};
  end

  // State register; reset drops any tenure without a cause pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_q     <= 2'd0;
      last_q    <= 2'd3;
      owner_q   <= 2'd0;
      beat_q    <= 4'd0;
      idle_q    <= 4'd0;
      ack_q     <= 3'b000;
      preempt_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      beat_q    <= beat_d;
      idle_q    <= idle_d;
      ack_q     <= ack_d;
      preempt_q <= preempt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.Ack1      = ack_q[0];
  assign bus.Ack2      = ack_q[1];
  assign bus.Ack3      = ack_q[2];
  assign bus.Owner     = owner_q;
  assign bus.BeatCount = beat_q;
  assign bus.Preempt   = preempt_q;
  assign bus.Timeout   = timeout_q;

endmodule
